// File: rtl/dma_sched_pkg.sv
// Shared types and helpers for the DMA write scheduler.
// - order_entry_t : {requester id, beat count} held in the grant-order queue
// - id_width()    : index width for a given requester count (minimum 1)
// - rr_find()     : round-robin first-set search starting at a pointer
package dma_sched_pkg;

  localparam int unsigned DefNReq     = 4;
  localparam int unsigned DefLenWidth = 9;
  // Widest request vector rr_find() accepts.
  localparam int unsigned RrMaxReq    = 32;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefIdWidth = id_width(DefNReq);

  // Order entries are sized by the package widths; the top's N_REQ and
  // CONFIG_LEN_WIDTH must match DefNReq/DefLenWidth.
  typedef struct packed {
    logic [DefIdWidth-1:0]  id;
    logic [DefLenWidth-1:0] len;
  } order_entry_t;

  // First set bit of req[n-1:0] at or after ptr, wrapping modulo n.
  function automatic logic rr_find(input  logic [RrMaxReq-1:0] req,
                                   input  int unsigned         ptr,
                                   input  int unsigned         n,
                                   output int unsigned         idx);
    logic [RrMaxReq-1:0] rot;
    int unsigned         cand;
    rr_find = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < RrMaxReq; k++) begin
      if (k < n && !rr_find) begin
        cand = (ptr + k) % n;
        rot  = req >> cand;
        if (rot[0]) begin
          rr_find = 1'b1;
          idx     = cand;
        end
      end
    end
  endfunction

endpackage

// File: rtl/dma_sched_oq.sv
// Grant-order queue: synchronous FIFO of {id, len} order entries.
// Ports: clk, rst (async, active high), push/push_entry (ignored when full),
// pop (ignored when empty), full, valid (non-empty), head (peek of oldest).
module dma_sched_oq
  import dma_sched_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  order_entry_t push_entry,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output order_entry_t head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  order_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CntW'(Depth));
  assign valid   = (cnt_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_wr_sched.sv
// Multi-requester front end for the DMA write engine.
// Round-robin arbitrates requester descriptors onto the engine config port,
// records grant order, then steers each requester's stream onto the engine
// data port in grant order for exactly the granted beat count.
// Ports: req_* per-requester descriptor/stream interfaces (packed, slice i =
// requester i); dma_config_* descriptor port; dma_valid_in/dma_data_in/
// dma_ready stream port; grant_id, data_owner, zero_len_drop, idle status.
module dma_wr_sched
  import dma_sched_pkg::*;
#(
  parameter int unsigned N_REQ             = DefNReq,
  parameter int unsigned AXI_ADDR_WIDTH    = 32,
  parameter int unsigned AXI_DATA_WIDTH    = 32,
  parameter int unsigned CONFIG_LEN_WIDTH  = DefLenWidth,
  parameter int unsigned OUTSTANDING_COUNT = 2,
  parameter int unsigned ID_WIDTH          = id_width(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [N_REQ*CONFIG_LEN_WIDTH-1:0]   req_len,
  input  logic [N_REQ-1:0]                    req_data_valid,
  input  logic [N_REQ*AXI_DATA_WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]                    req_data_ready,
  output logic                                dma_config_valid,
  input  logic                                dma_config_ready,
  output logic [AXI_ADDR_WIDTH-1:0]           dma_config_addr,
  output logic [CONFIG_LEN_WIDTH-1:0]         dma_config_len,
  input  logic                                dma_config_empty,
  output logic                                dma_valid_in,
  output logic [AXI_DATA_WIDTH-1:0]           dma_data_in,
  input  logic                                dma_ready,
  output logic [ID_WIDTH-1:0]                 grant_id,
  output logic [ID_WIDTH-1:0]                 data_owner,
  output logic                                zero_len_drop,
  output logic                                idle
);

  logic                        found, issue_ok, beat, last_beat;
  int unsigned                 g_idx;
  logic [ID_WIDTH-1:0]         g, hid;
  logic [CONFIG_LEN_WIDTH-1:0] g_len, hlen;
  logic [ID_WIDTH-1:0]         rr_ptr_q, rr_ptr_d, grant_id_q;
  logic [CONFIG_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                        zld_q;
  logic                        oq_full, oq_valid, oq_pop;
  order_entry_t                push_entry, head;

  dma_sched_oq #(
    .Depth(OUTSTANDING_COUNT)
  ) u_oq (
    .clk       (clk),
    .rst       (rst),
    .push      (dma_config_valid),
    .push_entry(push_entry),
    .pop       (oq_pop),
    .full      (oq_full),
    .valid     (oq_valid),
    .head      (head)
  );

  // Descriptor arbitration.
  always_comb begin
    found    = rr_find(RrMaxReq'(req_valid), 32'(rr_ptr_q), N_REQ, g_idx);
    g        = ID_WIDTH'(g_idx);
    g_len    = CONFIG_LEN_WIDTH'(req_len >> (g_idx * CONFIG_LEN_WIDTH));
    rr_ptr_d = (g_idx == N_REQ - 1) ? '0 : ID_WIDTH'(g_idx + 1);
    // Gating with rst keeps the handshake outputs low throughout reset.
    issue_ok = ~rst & found & ~oq_full & dma_config_ready;
    req_ready = issue_ok ? (N_REQ'(1) << g) : '0;
    // Engine pushes on valid alone, so valid already includes its ready.
    dma_config_valid = issue_ok & (g_len != '0);
    dma_config_addr  = AXI_ADDR_WIDTH'(req_addr >> (g_idx * AXI_ADDR_WIDTH));
    dma_config_len   = g_len;
    push_entry.id    = DefIdWidth'(g);
    push_entry.len   = DefLenWidth'(g_len);
  end

  // Data steering from the order-queue head.
  always_comb begin
    hid            = ID_WIDTH'(head.id);
    hlen           = CONFIG_LEN_WIDTH'(head.len);
    data_owner     = hid;
    dma_valid_in   = oq_valid & req_data_valid[hid];
    dma_data_in    = AXI_DATA_WIDTH'(req_data >> (32'(hid) * AXI_DATA_WIDTH));
    req_data_ready = (oq_valid & dma_ready) ? (N_REQ'(1) << hid) : '0;
    beat           = dma_valid_in & dma_ready;
    last_beat      = (beat_cnt_q == hlen - 1'b1);
    oq_pop         = beat & last_beat;
    beat_cnt_d     = beat_cnt_q;
    if (beat) beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    idle           = ~oq_valid & dma_config_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      zld_q      <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      if (issue_ok) begin
        rr_ptr_q   <= rr_ptr_d;
        grant_id_q <= g;
      end
      zld_q      <= issue_ok & (g_len == '0);
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id      = grant_id_q;
  assign zero_len_drop = zld_q;

endmodule

// File: tb/tb_dma_wr_sched.sv
// Randomized scoreboard bench for dma_wr_sched. The driver process keeps a
// descriptor/stream-level reference model and queues per-cycle expectations
// and expected data beats; the monitor process pops and compares them.
module tb_dma_wr_sched;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 9;
  localparam int IW  = 2;
  localparam int OUT = 2;
  localparam int NW  = 1024;

  logic            clk, rst;
  logic [N-1:0]    req_valid, req_ready, req_data_valid, req_data_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic            dma_config_valid, dma_config_ready, dma_config_empty;
  logic [AW-1:0]   dma_config_addr;
  logic [LW-1:0]   dma_config_len;
  logic            dma_valid_in, dma_ready, zero_len_drop, idle;
  logic [DW-1:0]   dma_data_in;
  logic [IW-1:0]   grant_id, data_owner;

  dma_wr_sched dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .req_data_valid  (req_data_valid),
    .req_data        (req_data),
    .req_data_ready  (req_data_ready),
    .dma_config_valid(dma_config_valid),
    .dma_config_ready(dma_config_ready),
    .dma_config_addr (dma_config_addr),
    .dma_config_len  (dma_config_len),
    .dma_config_empty(dma_config_empty),
    .dma_valid_in    (dma_valid_in),
    .dma_data_in     (dma_data_in),
    .dma_ready       (dma_ready),
    .grant_id        (grant_id),
    .data_owner      (data_owner),
    .zero_len_drop   (zero_len_drop),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; } desc_t;
  typedef struct { int id; int rem; } ent_t;
  typedef struct {
    logic [N-1:0] rdy;  logic cfg_v; logic [AW-1:0] addr; logic [LW-1:0] len;
    logic idle; logic dvi; logic [N-1:0] drdy; logic [IW-1:0] gid; logic zld;
  } cyc_t;
  typedef struct { logic [DW-1:0] data; logic [IW-1:0] id; } beat_t;

  desc_t         desc_q [N][$];
  ent_t          mq[$];
  cyc_t          exp_cyc[$];
  beat_t         exp_beat[$];
  logic [DW-1:0] words [N][NW];
  int            word_idx [N];
  int            next_assign [N];
  int            rr_ptr, last_g;
  logic          zld_now;
  int            arr_pct, cfg_pct, dr_pct, dv_pct, empty_pct, max_len;
  bit            fair_mode, mon_en;
  int            n_cmp, n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic push_desc(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    desc_t d;
    d.addr = a;
    d.len  = l;
    desc_q[i].push_back(d);
  endtask

  // One clock: drive at negedge, predict at negedge+1, commit model at posedge.
  task automatic cycle();
    cyc_t  e;
    desc_t d;
    ent_t  h;
    bit    found, issue, beat;
    int    g, hid;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (fair_mode) begin
        if (desc_q[i].size() == 0) push_desc(i, $urandom, LW'(1));
      end else if (desc_q[i].size() < 3 && pct(arr_pct)) begin
        push_desc(i, $urandom, ($urandom_range(7) == 0) ? '0 : LW'($urandom_range(1, max_len)));
      end
      req_valid[i] = (desc_q[i].size() != 0);
      req_addr[i*AW +: AW] = req_valid[i] ? desc_q[i][0].addr : '0;
      req_len[i*LW +: LW]  = req_valid[i] ? desc_q[i][0].len : '0;
      req_data_valid[i]    = pct(dv_pct);
      req_data[i*DW +: DW] = words[i][word_idx[i] % NW];
    end
    dma_config_ready = pct(cfg_pct);
    dma_ready        = pct(dr_pct);
    dma_config_empty = pct(empty_pct);
    #1;
    found = 0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && desc_q[(rr_ptr + k) % N].size() != 0) begin
        found = 1;
        g     = (rr_ptr + k) % N;
      end
    end
    issue = found && (mq.size() < OUT) && dma_config_ready;
    e = '{default: '0};
    d = '{default: '0};
    if (issue) begin
      d          = desc_q[g][0];
      e.rdy[g]   = 1'b1;
      e.cfg_v    = (d.len != 0);
      e.addr     = d.addr;
      e.len      = d.len;
    end
    hid = (mq.size() != 0) ? mq[0].id : 0;
    if (mq.size() != 0) begin
      e.dvi = req_data_valid[hid];
      if (dma_ready) e.drdy[hid] = 1'b1;
    end
    e.idle = (mq.size() == 0) && dma_config_empty;
    e.gid  = IW'(last_g);
    e.zld  = zld_now;
    exp_cyc.push_back(e);
    if (issue) begin
      for (int b = 0; b < int'(d.len); b++) begin
        exp_beat.push_back('{data: words[g][next_assign[g] % NW], id: IW'(g)});
        next_assign[g]++;
      end
    end
    beat = (mq.size() != 0) && req_data_valid[hid] && dma_ready;
    @(posedge clk);
    if (beat) begin
      word_idx[hid]++;
      h = mq[0];
      h.rem--;
      if (h.rem == 0) void'(mq.pop_front());
      else mq[0] = h;
    end
    zld_now = 1'b0;
    if (issue) begin
      void'(desc_q[g].pop_front());
      rr_ptr = (g + 1) % N;
      last_g = g;
      if (d.len != 0) mq.push_back('{id: g, rem: int'(d.len)});
      else zld_now = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_req_data_ready"}, req_data_ready, 0);
    chk({tag, "_cfg_valid"}, dma_config_valid, 0);
    chk({tag, "_valid_in"}, dma_valid_in, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_data_owner"}, data_owner, 0);
    chk({tag, "_zero_len_drop"}, zero_len_drop, 0);
  endtask

  task automatic clear_model();
    exp_cyc.delete();
    exp_beat.delete();
    mq.delete();
    for (int i = 0; i < N; i++) begin
      desc_q[i].delete();
      next_assign[i] = word_idx[i];
    end
    rr_ptr  = 0;
    last_g  = 0;
    zld_now = 1'b0;
  endtask

  task automatic async_reset();
    mon_en = 1'b0;
    @(negedge clk);
    #3;
    rst            = 1'b1;
    req_valid      = '0;
    req_data_valid = '0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    clear_model();
    rst = 1'b0;
    #3;
    mon_en = 1'b1;
  endtask

  task automatic set_knobs(input int a, input int c, input int r, input int v, input int e);
    arr_pct   = a;
    cfg_pct   = c;
    dr_pct    = r;
    dv_pct    = v;
    empty_pct = e;
  endtask

  // Monitor: compares every cycle's outputs and every data beat.
  cyc_t  mon_e;
  beat_t mon_b;
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (exp_cyc.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL cyc_exp: got empty expectation queue, required one entry");
      end else begin
        mon_e = exp_cyc.pop_front();
        chk("req_ready", req_ready, mon_e.rdy);
        chk("cfg_valid", dma_config_valid, mon_e.cfg_v);
        if (mon_e.cfg_v) begin
          chk("cfg_addr", dma_config_addr, mon_e.addr);
          chk("cfg_len", dma_config_len, mon_e.len);
        end
        chk("idle", idle, mon_e.idle);
        chk("dma_valid_in", dma_valid_in, mon_e.dvi);
        chk("req_data_ready", req_data_ready, mon_e.drdy);
        chk("grant_id", grant_id, mon_e.gid);
        chk("zero_len_drop", zero_len_drop, mon_e.zld);
      end
      if (dma_valid_in && dma_ready) begin
        if (exp_beat.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat: got data %0h with no beat expected", dma_data_in);
        end else begin
          mon_b = exp_beat.pop_front();
          chk("beat_data", dma_data_in, mon_b.data);
          chk("beat_owner", data_owner, mon_b.id);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    mon_en = 1'b0;
    fair_mode = 1'b0;
    max_len = 6;
    for (int i = 0; i < N; i++) begin
      word_idx[i] = 0;
      for (int k = 0; k < NW; k++) words[i][k] = $urandom;
    end
    clear_model();
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    req_data_valid = '0;
    req_data = '0;
    dma_config_ready = 1'b1;
    dma_config_empty = 1'b1;
    dma_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    mon_en = 1'b1;

    // Single request.
    set_knobs(0, 100, 100, 100, 100);
    push_desc(2, 32'h1000, LW'(4));
    repeat (8) cycle();

    // Round-robin fairness with len-1 descriptors on every requester.
    fair_mode = 1'b1;
    repeat (24) cycle();
    fair_mode = 1'b0;
    repeat (12) cycle();

    // Config backpressure.
    set_knobs(0, 0, 100, 100, 100);
    push_desc(1, 32'h2000, LW'(3));
    repeat (5) cycle();
    cfg_pct = 100;
    repeat (8) cycle();

    // Ordering: requester 0 streams early behind requester 3.
    push_desc(3, 32'h3000, LW'(2));
    cycle();
    push_desc(0, 32'h3100, LW'(3));
    repeat (10) cycle();

    // Zero-length descriptor.
    push_desc(1, 32'h3200, '0);
    repeat (4) cycle();

    // Random traffic.
    set_knobs(30, 80, 70, 70, 50);
    repeat (1500) cycle();

    // Drain, then reset in the middle of a 4-beat burst.
    set_knobs(0, 100, 100, 100, 100);
    repeat (40) cycle();
    push_desc(2, 32'h4000, LW'(4));
    repeat (3) cycle();
    async_reset();
    push_desc(2, 32'h5000, LW'(2));
    repeat (8) cycle();

    chk("beats_left", 64'(exp_beat.size()), 0);
    chk("model_queue_left", 64'(mq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_wr_sched.md
Name: dma_wr_sched

Overview:
- Multi-requester front end for the DMA write engine.
- Round-robin arbitrates N_REQ requesters' write descriptors (addr, beat length) onto the engine's single config port.
- Records grant order in an order queue. Steers each requester's data stream onto the engine's data port in exactly that order, for exactly the granted beat count.
- Sits between client stream producers and the DMA write block.

Parameters:
N_REQ, 4, number of requesters (>=2)
AXI_ADDR_WIDTH, 32, descriptor address width
AXI_DATA_WIDTH, 32, stream data width
CONFIG_LEN_WIDTH, 9, descriptor length width in beats
OUTSTANDING_COUNT, 2, order-queue depth; matches the engine's descriptor FIFO depth
ID_WIDTH, $clog2(N_REQ), requester index width

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester descriptor valid
req_ready  out  N_REQ  per-requester descriptor accept
req_addr  in  N_REQ*AXI_ADDR_WIDTH  packed descriptor addresses, requester i at slice i
req_len  in  N_REQ*CONFIG_LEN_WIDTH  packed beat counts
req_data_valid  in  N_REQ  per-requester stream valid
req_data  in  N_REQ*AXI_DATA_WIDTH  packed stream data
req_data_ready  out  N_REQ  per-requester stream ready
dma_config_valid  out  1  descriptor to engine
dma_config_ready  in  1  engine descriptor FIFO not full
dma_config_addr  out  AXI_ADDR_WIDTH  forwarded address
dma_config_len  out  CONFIG_LEN_WIDTH  forwarded beat count
dma_config_empty  in  1  engine idle (no queued/active descriptor)
dma_valid_in  out  1  stream beat to engine
dma_data_in  out  AXI_DATA_WIDTH  stream data to engine
dma_ready  in  1  engine stream ready
grant_id  out  ID_WIDTH  requester of last issued descriptor
data_owner  out  ID_WIDTH  requester currently owning the data port
zero_len_drop  out  1  one-cycle pulse: len=0 descriptor consumed, not forwarded
idle  out  1  order queue empty and dma_config_empty

Behaviour:
- Reset (rst high, async), all outputs and state cleared:
  - rr_ptr=0, order queue empty, beat_cnt=0.
  - grant_id=0, data_owner=0, zero_len_drop=0.
  - req_ready, req_data_ready, dma_config_valid and dma_valid_in all 0.
- Reset mid-operation discards queue contents and partial beat counts. The engine is reset in the same domain event.
- Arbitration (combinational grant, registered pointer):
  - Candidate g = first i with req_valid[i], searching from rr_ptr upward, wrapping modulo N_REQ.
  - issue_ok = (candidate exists) & ~oq_full & dma_config_ready.
- dma_config_valid = issue_ok & (req_len[g] != 0).
  - It is never asserted while dma_config_ready=0: the engine pushes on valid alone, with no handshake check.
- req_ready[g] = issue_ok; all other req_ready bits are 0. A descriptor is consumed in the cycle req_valid[g] & req_ready[g].
- On consume:
  - rr_ptr <= (g+1) mod N_REQ.
  - grant_id <= g.
  - If len != 0: push {g, len} into the order queue.
  - If len == 0: no push, no dma_config_valid; zero_len_drop pulses next cycle.
- Push is gated by ~oq_full evaluated before this cycle's pop. There is no same-cycle push-through on full.
- Data steering, driven by the order-queue head {hid, hlen}:
  - data_owner = hid.
  - dma_valid_in = oq_valid & req_data_valid[hid]; dma_data_in = req_data[hid].
  - req_data_ready[hid] = oq_valid & dma_ready; all other bits are 0.
- On a beat (dma_valid_in & dma_ready):
  - If beat_cnt == hlen-1: beat_cnt <= 0 and pop the head.
  - Otherwise beat_cnt <= beat_cnt+1.
  - beat_cnt width is CONFIG_LEN_WIDTH.
- Latency:
  - Descriptor: zero cycles from req_valid to dma_config_valid.
  - Data of a newly pushed head: first beat may pass the cycle after the push.
  - Back-to-back heads: the next owner's beat may pass the cycle after the previous last beat. No bubble is required.
- Simultaneous descriptor issue and head pop are both honoured.
- A requester may hold several queue entries. Its data is consumed in its own descriptor order.
- idle = ~oq_valid & dma_config_empty.

Decomposition:
- Package dma_sched_pkg:
  - Order-entry struct {id, len}.
  - Localparam helper for ID_WIDTH.
  - Round-robin find-first function (pointer, request vector -> index, found).
- Sub-module dma_sched_oq: synchronous FIFO of order entries.
  - Depth OUTSTANDING_COUNT; outputs full, valid, and head peek.
  - Async active-high reset.

Test Plan:
- Single request: req 2 valid, addr 0x1000, len 4; then 4 data beats -> one dma_config_valid cycle with addr 0x1000, len 4. Data port owner 2 for exactly 4 beats, then idle=1 once dma_config_empty=1.
- Round-robin fairness: all 4 requesters valid continuously, each len 1, dma always ready -> grant_id sequence 0,1,2,3,0,...; queue never exceeds 2 entries.
- Backpressure: dma_config_ready=0 for 5 cycles with req 1 valid -> dma_config_valid and req_ready stay 0. Issue occurs the first cycle ready=1.
- Ordering: req 3 len 2 then req 0 len 3 queued; req 0 streams data early -> req_data_ready[0]=0 until req 3's 2 beats pass. Then req 0 gets 3 beats.
- Zero length: req 1 len 0 -> req_ready[1]=1 for one cycle, no dma_config_valid, zero_len_drop pulses, queue unchanged.
- Async reset: assert rst mid-burst (beat 2 of 4) -> all outputs 0 immediately; after release, a new len 2 request completes normally.
